// File: rtl/mem_store_unit_if.sv
// Store-unit bus bundle: execute-stage store request, DMEM/IMEM write ports,
// memory-mapped IO store handshake and the queue-empty status.
interface mem_store_unit_if #(
  parameter int MEM_AW = 14
);
  logic              st_valid_i;
  logic              st_ready_o;
  logic [31:0]       st_addr_i;
  logic [31:0]       st_data_i;
  logic [2:0]        st_funct3_i;
  logic              imem_wr_allow_i;

  logic [MEM_AW-1:0] dmem_addr_o;
  logic [31:0]       dmem_din_o;
  logic [3:0]        dmem_we_o;

  logic [MEM_AW-1:0] imem_addr_o;
  logic [31:0]       imem_din_o;
  logic [3:0]        imem_we_o;

  logic              io_valid_o;
  logic              io_ready_i;
  logic [31:0]       io_addr_o;
  logic [31:0]       io_data_o;
  logic [3:0]        io_we_o;

  logic              empty_o;

  modport master (
    output st_valid_i, st_addr_i, st_data_i, st_funct3_i, imem_wr_allow_i, io_ready_i,
    input  st_ready_o, dmem_addr_o, dmem_din_o, dmem_we_o,
           imem_addr_o, imem_din_o, imem_we_o,
           io_valid_o, io_addr_o, io_data_o, io_we_o, empty_o
  );

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, st_funct3_i, imem_wr_allow_i, io_ready_i,
    output st_ready_o, dmem_addr_o, dmem_din_o, dmem_we_o,
           imem_addr_o, imem_din_o, imem_we_o,
           io_valid_o, io_addr_o, io_data_o, io_we_o, empty_o
  );
endinterface

// File: rtl/mem_store_unit.sv
// Store-side memory stage: aligns stores, decodes the target region and drains
// an in-order store queue to DMEM, IMEM or IO. STORE_MISALIGN_TRAP_EN adds misalign_o.
module mem_store_unit #(
  parameter int DEPTH  = 4,
  parameter int MEM_AW = 14
) (
  input  logic             clk,
  input  logic             rst,
  mem_store_unit_if.slave  bus
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic             misalign_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_DMEM = 2'd1,
    TGT_IMEM = 2'd2,
    TGT_IO   = 2'd3
  } target_t;

  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  target_t           tgt_q   [DEPTH];
  logic [MEM_AW-1:0] waddr_q [DEPTH];
  logic [31:0]       faddr_q [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic [3:0]        we_q    [DEPTH];

  logic [3:0]        al_we;
  logic [31:0]       al_data;
  logic              misaligned;
  target_t           al_tgt;
  logic              handshake;
  logic              push;
  logic              pop;
  logic              not_empty;
  target_t           head_tgt;

  // Lane replication plus byte enables; unknown funct3 codes behave as SW.
  always_comb begin
    al_we      = 4'b1111;
    al_data    = bus.st_data_i;
    misaligned = 1'b0;
    case (bus.st_funct3_i)
      3'b000: begin
        al_we   = 4'b0001 << bus.st_addr_i[1:0];
        al_data = {4{bus.st_data_i[7:0]}};
      end
      3'b001: begin
        al_we      = bus.st_addr_i[1] ? 4'b1100 : 4'b0011;
        al_data    = {2{bus.st_data_i[15:0]}};
        misaligned = bus.st_addr_i[0];
      end
      default: begin
        al_we      = 4'b1111;
        al_data    = bus.st_data_i;
        misaligned = (bus.st_addr_i[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    al_tgt = TGT_NONE;
    case (bus.st_addr_i[31:28])
      4'h1:    al_tgt = TGT_DMEM;
      4'h2:    al_tgt = bus.imem_wr_allow_i ? TGT_IMEM : TGT_NONE;
      4'h8:    al_tgt = TGT_IO;
      default: al_tgt = TGT_NONE;
    endcase
  end

  // Dropped requests still complete the handshake so the pipeline never stalls on them.
  assign bus.st_ready_o = (count != FULL);
  assign handshake      = bus.st_valid_i && bus.st_ready_o;
  assign push           = handshake && !misaligned && (al_tgt != TGT_NONE);
  assign not_empty      = (count != '0);
  assign head_tgt       = tgt_q[rd_ptr];
  assign pop            = not_empty && ((head_tgt != TGT_IO) || bus.io_ready_i);
  assign bus.empty_o    = !not_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: nothing is visible unless count covers the slot.
  always_ff @(posedge clk) begin
    if (push) begin
      tgt_q[wr_ptr]   <= al_tgt;
      waddr_q[wr_ptr] <= bus.st_addr_i[MEM_AW+1:2];
      faddr_q[wr_ptr] <= {bus.st_addr_i[31:2], 2'b00};
      data_q[wr_ptr]  <= al_data;
      we_q[wr_ptr]    <= al_we;
    end
  end

  always_comb begin
    bus.dmem_addr_o = '0;
    bus.dmem_din_o  = '0;
    bus.dmem_we_o   = '0;
    bus.imem_addr_o = '0;
    bus.imem_din_o  = '0;
    bus.imem_we_o   = '0;
    bus.io_valid_o  = 1'b0;
    bus.io_addr_o   = '0;
    bus.io_data_o   = '0;
    bus.io_we_o     = '0;
    if (not_empty) begin
      case (head_tgt)
        TGT_DMEM: begin
          bus.dmem_addr_o = waddr_q[rd_ptr];
          bus.dmem_din_o  = data_q[rd_ptr];
          bus.dmem_we_o   = we_q[rd_ptr];
        end
        TGT_IMEM: begin
          bus.imem_addr_o = waddr_q[rd_ptr];
          bus.imem_din_o  = data_q[rd_ptr];
          bus.imem_we_o   = we_q[rd_ptr];
        end
        TGT_IO: begin
          bus.io_valid_o = 1'b1;
          bus.io_addr_o  = faddr_q[rd_ptr];
          bus.io_data_o  = data_q[rd_ptr];
          bus.io_we_o    = we_q[rd_ptr];
        end
        default: ;
      endcase
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= handshake && misaligned;
  end
`endif

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed self-checking bench for mem_store_unit: alignment, region decode,
// drops, IO back-pressure, program ordering and mid-drain reset.
module tb_mem_store_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_store_unit_if #(.MEM_AW(14)) bus ();

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign;
  mem_store_unit #(.DEPTH(4), .MEM_AW(14)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .misalign_o (misalign)
  );
`else
  mem_store_unit #(.DEPTH(4), .MEM_AW(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] funct3,
                               input logic allow);
    bus.st_valid_i      = valid;
    bus.st_addr_i       = addr;
    bus.st_data_i       = data;
    bus.st_funct3_i     = funct3;
    bus.imem_wr_allow_i = allow;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.io_ready_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    tick();
    tick();
    checkOutput("rst_empty", bus.empty_o, 1);
    checkOutput("rst_ready", bus.st_ready_o, 1);
    checkOutput("rst_dmem_we", bus.dmem_we_o, 0);
    checkOutput("rst_imem_we", bus.imem_we_o, 0);
    checkOutput("rst_io_valid", bus.io_valid_o, 0);
    checkOutput("rst_io_we", bus.io_we_o, 0);
    checkOutput("rst_dmem_addr", bus.dmem_addr_o, 0);
    checkOutput("rst_io_addr", bus.io_addr_o, 0);
    checkOutput("rst_io_data", bus.io_data_o, 0);
`ifdef STORE_MISALIGN_TRAP_EN
    checkOutput("rst_misalign", misalign, 0);
`endif
    rst = 1'b0;
    tick();

    // SB to the top byte lane of DMEM word 0
    applyStimulus(1'b1, 32'h1000_0003, 32'h0000_00AB, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    checkOutput("sb_we", bus.dmem_we_o, 32'h8);
    checkOutput("sb_din", bus.dmem_din_o, 32'hABAB_ABAB);
    checkOutput("sb_addr", bus.dmem_addr_o, 0);
    checkOutput("sb_not_empty", bus.empty_o, 0);
    checkOutput("sb_imem_idle", bus.imem_we_o, 0);
    tick();
    checkOutput("sb_empty_after", bus.empty_o, 1);
    checkOutput("sb_we_after", bus.dmem_we_o, 0);

    // SH to the upper half of DMEM word 1
    applyStimulus(1'b1, 32'h1000_0006, 32'h0000_1234, 3'b001, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    checkOutput("sh_we", bus.dmem_we_o, 32'hC);
    checkOutput("sh_din", bus.dmem_din_o, 32'h1234_1234);
    checkOutput("sh_addr", bus.dmem_addr_o, 1);
    tick();

    // SW to IMEM with writes allowed
    applyStimulus(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 3'b010, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    checkOutput("imem_we", bus.imem_we_o, 32'hF);
    checkOutput("imem_din", bus.imem_din_o, 32'hDEAD_BEEF);
    checkOutput("imem_addr", bus.imem_addr_o, 4);
    checkOutput("imem_dmem_idle", bus.dmem_we_o, 0);
    tick();

    // Fill the queue with four IO words while the target is not ready
    bus.io_ready_i = 1'b0;
    applyStimulus(1'b1, 32'h8000_0008, 32'h0000_0001, 3'b010, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0008, 32'h0000_0002, 3'b010, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0008, 32'h0000_0003, 3'b010, 1'b0);
    tick();
    checkOutput("fill_ready_at3", bus.st_ready_o, 1);
    applyStimulus(1'b1, 32'h8000_0008, 32'h0000_0004, 3'b010, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    checkOutput("full_ready", bus.st_ready_o, 0);
    checkOutput("full_io_valid", bus.io_valid_o, 1);
    checkOutput("full_io_data", bus.io_data_o, 1);
    checkOutput("full_io_addr", bus.io_addr_o, 32'h8000_0008);
    checkOutput("full_io_we", bus.io_we_o, 32'hF);
    tick();
    checkOutput("hold_io_valid", bus.io_valid_o, 1);
    checkOutput("hold_io_data", bus.io_data_o, 1);
    checkOutput("hold_io_addr", bus.io_addr_o, 32'h8000_0008);
    // A full queue refuses a DMEM store even in the cycle it pops
    bus.io_ready_i = 1'b1;
    applyStimulus(1'b1, 32'h1000_0000, 32'h5555_5555, 3'b010, 1'b0);
    checkOutput("pop_cycle_ready", bus.st_ready_o, 0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    checkOutput("after_pop_ready", bus.st_ready_o, 1);
    checkOutput("drain_io_2", bus.io_data_o, 2);
    tick();
    checkOutput("drain_io_3", bus.io_data_o, 3);
    tick();
    checkOutput("drain_io_4", bus.io_data_o, 4);
    tick();
    checkOutput("drain_empty", bus.empty_o, 1);
    checkOutput("drain_io_valid", bus.io_valid_o, 0);
    checkOutput("refused_no_dmem", bus.dmem_we_o, 0);
    bus.io_ready_i = 1'b0;

    // Misaligned SW, disallowed IMEM and unmapped stores are all dropped
    applyStimulus(1'b1, 32'h1000_0002, 32'h1111_1111, 3'b010, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h2000_0000, 32'h2222_2222, 3'b010, 1'b0);
`ifdef STORE_MISALIGN_TRAP_EN
    checkOutput("trap_pulse", misalign, 1);
`endif
    checkOutput("drop1_empty", bus.empty_o, 1);
    checkOutput("drop1_dmem_we", bus.dmem_we_o, 0);
    tick();
    applyStimulus(1'b1, 32'h3000_0000, 32'h3333_3333, 3'b010, 1'b1);
`ifdef STORE_MISALIGN_TRAP_EN
    checkOutput("trap_no_imem_pulse", misalign, 0);
`endif
    checkOutput("drop2_empty", bus.empty_o, 1);
    checkOutput("drop2_imem_we", bus.imem_we_o, 0);
    tick();
    applyStimulus(0, 32'h0, 32'h0, 3'b010, 1'b0);
    checkOutput("drop3_empty", bus.empty_o, 1);
    checkOutput("drop3_ready", bus.st_ready_o, 1);
    checkOutput("drop3_io_valid", bus.io_valid_o, 0);
`ifdef STORE_MISALIGN_TRAP_EN
    checkOutput("trap_no_unmapped_pulse", misalign, 0);
`endif

    // DMEM, IO, DMEM with IO back-pressure: second DMEM write must wait
    applyStimulus(1'b1, 32'h1000_0010, 32'h0000_00A1, 3'b010, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0005, 32'h0000_005A, 3'b000, 1'b0);
    checkOutput("mix_d1_we", bus.dmem_we_o, 32'hF);
    checkOutput("mix_d1_addr", bus.dmem_addr_o, 4);
    checkOutput("mix_d1_din", bus.dmem_din_o, 32'hA1);
    tick();
    applyStimulus(1'b1, 32'h1000_0014, 32'h0000_00C3, 3'b010, 1'b0);
    checkOutput("mix_io_valid", bus.io_valid_o, 1);
    checkOutput("mix_io_we", bus.io_we_o, 32'h2);
    checkOutput("mix_io_addr", bus.io_addr_o, 32'h8000_0004);
    checkOutput("mix_io_data", bus.io_data_o, 32'h5A5A_5A5A);
    checkOutput("mix_wait1", bus.dmem_we_o, 0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    checkOutput("mix_wait2", bus.dmem_we_o, 0);
    checkOutput("mix_io_hold", bus.io_valid_o, 1);
    tick();
    checkOutput("mix_wait3", bus.dmem_we_o, 0);
    bus.io_ready_i = 1'b1;
    #1;
    checkOutput("mix_io_accept", bus.io_valid_o, 1);
    tick();
    bus.io_ready_i = 1'b0;
    #1;
    checkOutput("mix_d2_we", bus.dmem_we_o, 32'hF);
    checkOutput("mix_d2_addr", bus.dmem_addr_o, 5);
    checkOutput("mix_d2_din", bus.dmem_din_o, 32'hC3);
    checkOutput("mix_d2_io_idle", bus.io_valid_o, 0);
    tick();
    checkOutput("mix_empty", bus.empty_o, 1);

    // Reset mid-drain discards queued IO stores
    applyStimulus(1'b1, 32'h8000_0100, 32'h0000_0010, 3'b010, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0104, 32'h0000_0020, 3'b010, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0108, 32'h0000_0030, 3'b010, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    checkOutput("pre_rst_io_valid", bus.io_valid_o, 1);
    checkOutput("pre_rst_io_data", bus.io_data_o, 32'h10);
    rst = 1'b1;
    #1;
    checkOutput("in_rst_io_valid", bus.io_valid_o, 0);
    checkOutput("in_rst_empty", bus.empty_o, 1);
    tick();
    rst = 1'b0;
    bus.io_ready_i = 1'b1;
    #1;
    checkOutput("post_rst_io_valid", bus.io_valid_o, 0);
    checkOutput("post_rst_empty", bus.empty_o, 1);
    checkOutput("post_rst_ready", bus.st_ready_o, 1);
    tick();
    checkOutput("post_rst_io_valid2", bus.io_valid_o, 0);
    checkOutput("post_rst_io_we", bus.io_we_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
